// File: rtl/triple_buffer_pkg.sv
// Shared types and constants for the triple-buffered frame RAM sequencer.
package triple_buffer_pkg;

  localparam int unsigned ADDR_W = 12;

  localparam logic [2:0] BANK0 = 3'b001;
  localparam logic [2:0] BANK1 = 3'b010;
  localparam logic [2:0] BANK2 = 3'b100;

  typedef enum logic {R_IDLE, R_READ} rd_state_e;

  typedef struct packed {
    logic [2:0] wb;
    logic [2:0] rb_rdy;
    logic [2:0] rb_rd;
  } roles_t;

  // Commit hands the written bank to ready; claim hands ready to the reader.
  // Both at once rotate all three, so the reader gets the old ready frame
  // and the fresh frame lands in ready.
  function automatic roles_t rotate_roles(input roles_t r, input logic commit,
                                          input logic claim);
    roles_t n;
    n = r;
    case ({commit, claim})
      2'b11: begin
        n.rb_rd  = r.rb_rdy;
        n.rb_rdy = r.wb;
        n.wb     = r.rb_rd;
      end
      2'b10: begin
        n.wb     = r.rb_rdy;
        n.rb_rdy = r.wb;
      end
      2'b01: begin
        n.rb_rd  = r.rb_rdy;
        n.rb_rdy = r.rb_rd;
      end
      default: ;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tap_counter.sv
// Frame tap index counter: advances on enable, wraps after MAX_TAP-1.
module tap_counter
  import triple_buffer_pkg::*;
#(
  parameter int unsigned MAX_TAP = 616,
  parameter int unsigned W       = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] LAST_VAL = W'(MAX_TAP - 1);

  assign last = (cnt == LAST_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/triple_buffer_ctrl.sv
// Three-bank frame sequencer: non-stalling writer, reader always gets the
// newest complete frame.
module triple_buffer_ctrl
  import triple_buffer_pkg::*;
#(
  parameter int unsigned MAX_TAP = 616,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic              flush,
  input  logic              rd_req,
  output logic [ADDR_W-1:0] waddr,
  output logic [2:0]        w_buffer_id,
  output logic              w_occur,
  output logic [ADDR_W-1:0] raddr,
  output logic [2:0]        r_buffer_id,
  output logic              r_occur,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              frame_avail,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam roles_t ROLES_RST = '{wb: BANK0, rb_rdy: BANK1, rb_rd: BANK2};

  rd_state_e state;
  roles_t    roles;
  logic      w_last;
  logic      r_last;
  logic      commit;
  logic      claim;

  assign w_occur = wr_valid & ~flush;
  assign commit  = w_occur & w_last;
  assign claim   = (state == R_IDLE) & rd_req & frame_avail;

  assign w_buffer_id = roles.wb;
  assign r_buffer_id = roles.rb_rd;

  tap_counter #(.MAX_TAP(MAX_TAP), .W(ADDR_W)) u_wtap (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_occur),
    .clr  (flush),
    .cnt  (waddr),
    .last (w_last)
  );

  tap_counter #(.MAX_TAP(MAX_TAP), .W(ADDR_W)) u_rtap (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (r_occur),
    .clr  (claim),
    .cnt  (raddr),
    .last (r_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= R_IDLE;
      r_occur <= 1'b0;
      rd_busy <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        R_IDLE: if (claim) begin
          state   <= R_READ;
          r_occur <= 1'b1;
          rd_busy <= 1'b1;
        end
        R_READ: if (r_last) begin
          state   <= R_IDLE;
          r_occur <= 1'b0;
          rd_busy <= 1'b0;
          rd_done <= 1'b1;
        end
        default: state <= R_IDLE;
      endcase
    end
  end

  // A drop is only a ready frame replaced without the reader taking it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roles       <= ROLES_RST;
      frame_avail <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      roles <= rotate_roles(roles, commit, claim);
      if (commit) begin
        frame_avail <= 1'b1;
      end else if (flush || claim) begin
        frame_avail <= 1'b0;
      end
      if (commit && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (commit && !claim && frame_avail && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_triple_buffer_ctrl.sv
// Scoreboard bench for triple_buffer_ctrl with a bank-index reference model.
module tb_triple_buffer_ctrl;

  localparam int unsigned MT = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic            clk;
  logic            rst_n;
  logic            wr_valid;
  logic            flush;
  logic            rd_req;
  logic [11:0]     waddr;
  logic [2:0]      w_buffer_id;
  logic            w_occur;
  logic [11:0]     raddr;
  logic [2:0]      r_buffer_id;
  logic            r_occur;
  logic            rd_busy;
  logic            rd_done;
  logic            frame_avail;
  logic [CW-1:0]   frame_cnt;
  logic [CW-1:0]   drop_cnt;

  triple_buffer_ctrl #(.MAX_TAP(MT), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .flush      (flush),
    .rd_req     (rd_req),
    .waddr      (waddr),
    .w_buffer_id(w_buffer_id),
    .w_occur    (w_occur),
    .raddr      (raddr),
    .r_buffer_id(r_buffer_id),
    .r_occur    (r_occur),
    .rd_busy    (rd_busy),
    .rd_done    (rd_done),
    .frame_avail(frame_avail),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] waddr;
    logic [11:0] raddr;
    logic [2:0]  wb;
    logic [2:0]  rd;
    logic        w_occur;
    logic        r_occur;
    logic        rd_done;
    logic        avail;
    int unsigned fcnt;
    int unsigned dcnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: roles as bank indices, read progress as a tap position.
  int unsigned m_w, m_rdy, m_rd, m_wa, m_ra, m_fc, m_dc;
  bit          m_reading, m_avail, m_done;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] oh(input int unsigned idx);
    logic [2:0] v;
    v = 3'b000;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_w = 0; m_rdy = 1; m_rd = 2;
    m_wa = 0; m_ra = 0; m_fc = 0; m_dc = 0;
    m_reading = 0; m_avail = 0; m_done = 0;
  endtask

  task automatic cycle(input bit wv, input bit fl, input bit rq);
    bit acc, commit, claim;
    int unsigned t;
    exp_t x;
    wr_valid = wv; flush = fl; rd_req = rq;
    acc    = wv && !fl;
    commit = acc && (m_wa == MT - 1);
    claim  = !m_reading && rq && m_avail;
    m_done = m_reading && (m_ra == MT - 1);
    if (fl) m_wa = 0;
    else if (acc) m_wa = commit ? 0 : m_wa + 1;
    if (claim) begin
      m_reading = 1; m_ra = 0;
    end else if (m_reading) begin
      if (m_ra == MT - 1) begin m_reading = 0; m_ra = 0; end
      else m_ra = m_ra + 1;
    end
    if (commit && m_fc < SAT) m_fc++;
    if (commit && !claim && m_avail && m_dc < SAT) m_dc++;
    t = m_rd;
    if (commit && claim) begin
      m_rd = m_rdy; m_rdy = m_w; m_w = t;
    end else if (commit) begin
      t = m_w; m_w = m_rdy; m_rdy = t;
    end else if (claim) begin
      m_rd = m_rdy; m_rdy = t;
    end
    if (commit) m_avail = 1;
    else if (fl || claim) m_avail = 0;
    x.waddr = 12'(m_wa); x.raddr = 12'(m_ra);
    x.wb = oh(m_w); x.rd = oh(m_rd);
    x.w_occur = acc; x.r_occur = m_reading; x.rd_done = m_done;
    x.avail = m_avail; x.fcnt = m_fc; x.dcnt = m_dc;
    sb_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0; flush = 1'b0; rd_req = 1'b0;
    #1;
    chk("rst_waddr", waddr, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_wbuf", w_buffer_id, 3'b001);
    chk("rst_rbuf", r_buffer_id, 3'b100);
    chk("rst_occur", {w_occur, r_occur, rd_busy, rd_done}, 0);
    chk("rst_avail", frame_avail, 0);
    chk("rst_cnts", {frame_cnt, drop_cnt}, 0);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("waddr", waddr, e.waddr);
      chk("raddr", raddr, e.raddr);
      chk("w_buffer_id", w_buffer_id, e.wb);
      chk("r_buffer_id", r_buffer_id, e.rd);
      chk("w_occur", w_occur, e.w_occur);
      chk("r_occur", r_occur, e.r_occur);
      chk("rd_busy", rd_busy, e.r_occur);
      chk("rd_done", rd_done, e.rd_done);
      chk("frame_avail", frame_avail, e.avail);
      chk("frame_cnt", frame_cnt, e.fcnt);
      chk("drop_cnt", drop_cnt, e.dcnt);
      chk("roles_onehot", {$onehot(w_buffer_id), $onehot(r_buffer_id)}, 2'b11);
      chk("roles_excl", w_buffer_id & r_buffer_id, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned taps;
    int unsigned dones;
    rst_n = 1'b0; wr_valid = 1'b0; flush = 1'b0; rd_req = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // One frame written and committed.
    repeat (MT) cycle(1, 0, 0);
    chk("s1_waddr", waddr, 0);
    chk("s1_wb", w_buffer_id, 3'b010);
    chk("s1_rdy", 3'b111 ^ (w_buffer_id | r_buffer_id), 3'b001);
    chk("s1_avail", frame_avail, 1);
    chk("s1_fcnt", frame_cnt, 1);

    // Single read: eight taps then a done pulse.
    cycle(0, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      chk("s2_occur", r_occur, (k <= 8) ? 1 : 0);
      chk("s2_done", rd_done, (k == 9) ? 1 : 0);
      if (k <= 8) chk("s2_raddr", raddr, k - 1);
      if (k <= 8) chk("s2_rbuf", r_buffer_id, 3'b001);
      if (k < 10) cycle(0, 0, 0);
    end
    chk("s2_avail", frame_avail, 0);

    // Continuous writes, no reader.
    do_reset();
    repeat (3 * MT) cycle(1, 0, 0);
    chk("s3_fcnt", frame_cnt, 3);
    chk("s3_drop", drop_cnt, 2);
    chk("s3_avail", frame_avail, 1);

    // Claim on the same edge as the second commit.
    do_reset();
    repeat (2 * MT - 1) cycle(1, 0, 0);
    cycle(1, 0, 1);
    chk("s4_rd", r_buffer_id, 3'b001);
    chk("s4_wb", w_buffer_id, 3'b100);
    chk("s4_rdy", 3'b111 ^ (w_buffer_id | r_buffer_id), 3'b010);
    chk("s4_avail", frame_avail, 1);
    chk("s4_drop", drop_cnt, 0);
    chk("s4_fcnt", frame_cnt, 2);
    repeat (MT + 2) cycle(0, 0, 0);

    // Flush mid-frame and on the terminal tap.
    do_reset();
    repeat (MT + 5) cycle(1, 0, 0);
    chk("s5_pre_waddr", waddr, 5);
    cycle(1, 1, 0);
    chk("s5_waddr", waddr, 0);
    chk("s5_avail", frame_avail, 0);
    chk("s5_fcnt", frame_cnt, 1);
    repeat (MT - 1) cycle(1, 0, 0);
    cycle(1, 1, 0);
    chk("s5_last_waddr", waddr, 0);
    chk("s5_last_fcnt", frame_cnt, 1);

    // Flush during a read leaves the read intact.
    do_reset();
    repeat (MT) cycle(1, 0, 0);
    cycle(0, 0, 1);
    taps = 0;
    for (int k = 0; k < 12; k++) begin
      if (r_occur) taps++;
      cycle(0, (k == 2) ? 1'b1 : 1'b0, 0);
    end
    chk("s5_taps", taps, MT);

    // Asynchronous reset mid-read.
    do_reset();
    repeat (MT) cycle(1, 0, 0);
    cycle(0, 0, 1);
    repeat (3) cycle(0, 0, 0);
    chk("s6_raddr", raddr, 3);
    do_reset();
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      if (rd_done) dones++;
      cycle(0, 0, 0);
    end
    chk("s6_no_done", dones, 0);

    // Counter saturation.
    do_reset();
    repeat (10 * MT) cycle(1, 0, 0);
    chk("s7_fcnt", frame_cnt, SAT);
    chk("s7_drop", drop_cnt, SAT);

    // Back-to-back reads with rd_req held, then random traffic.
    do_reset();
    repeat (5 * MT) cycle(1, 0, 1);
    repeat (400) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                       $urandom_range(0, 1) == 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
